// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
//
// Instruction queue between the Fetch and Decode stages of a 5-stage MIPS
// pipeline. Fetched {instr, pc} pairs are held in a small circular buffer and
// presented to Decode in strict FIFO order. Decode stalls are absorbed until
// the buffer is full, and then back-pressure is applied to Fetch's PC enable.
// A one-cycle flush discards everything for pipeline redirects.
//
// Parameters
//   DEPTH     number of entries (power of two, >= 2)
//   RESET_PC  pc_d value out of reset / after flush while nothing was popped
//
// Ports
//   clk      in   pipeline clock, rising edge
//   reset    in   asynchronous, active-low reset
//   instr_f  in   32-bit instruction from Fetch
//   pc_f     in   32-bit PC of instr_f
//   valid_f  in   instr_f/pc_f carry a real fetched word
//   ready_f  out  queue can accept a word (Fetch PC enable)
//   instr_d  out  head instruction to Decode (nop when empty)
//   pc_d     out  PC of head instruction (last popped PC when empty)
//   pc8_d    out  pc_d + 8, link address for jal/jalr
//   valid_d  out  head entry is valid
//   ready_d  in   Decode accepts the head this cycle
//   flush    in   discard all queued and incoming words
//   count    out  number of valid entries
// -----------------------------------------------------------------------------
module if_id_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  instr_f,
  input  logic [31:0]                  pc_f,
  input  logic                         valid_f,
  output logic                         ready_f,
  output logic [31:0]                  instr_d,
  output logic [31:0]                  pc_d,
  output logic [31:0]                  pc8_d,
  output logic                         valid_d,
  input  logic                         ready_d,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic [31:0]   held_pc;
  logic          push;
  logic          pop;

  // ready_f depends only on the registered count, so Decode's ready_d never
  // reaches Fetch combinationally; a pop frees space from the next cycle.
  assign ready_f = (cnt != CW'(DEPTH));
  assign valid_d = (cnt != '0);
  assign count   = cnt;

  assign push = valid_f && ready_f && !flush;
  assign pop  = valid_d && ready_d && !flush;

  assign instr_d = valid_d ? mem_instr[head] : 32'h0000_0000;
  assign pc_d    = valid_d ? mem_pc[head]    : held_pc;
  assign pc8_d   = pc_d + 32'd8;

  // Storage carries data only; its contents are meaningless until written,
  // so it is not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[tail] <= instr_f;
      mem_pc[tail]    <= pc_f;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      held_pc <= RESET_PC;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      held_pc <= RESET_PC;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head    <= head + PW'(1);
        // Remember the departing PC so pc_d holds steady once the queue drains.
        held_pc <= mem_pc[head];
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          CW       = $clog2(DEPTH+1);
  localparam int          VW       = 98 + CW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   instr_f = '0;
  logic [31:0]   pc_f = '0;
  logic          valid_f = 1'b0;
  logic          ready_f;
  logic [31:0]   instr_d;
  logic [31:0]   pc_d;
  logic [31:0]   pc8_d;
  logic          valid_d;
  logic          ready_d = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  // Reference model: a plain queue of fetched words plus the last popped PC.
  ent_t        q[$];
  logic [31:0] last_pc = RESET_PC;

  logic [VW-1:0] obs;
  assign obs = {ready_f, valid_d, instr_d, pc_d, pc8_d, count};

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .instr_f(instr_f), .pc_f(pc_f),
    .valid_f(valid_f), .ready_f(ready_f), .instr_d(instr_d), .pc_d(pc_d),
    .pc8_d(pc8_d), .valid_d(valid_d), .ready_d(ready_d), .flush(flush),
    .count(count)
  );

  function automatic logic [VW-1:0] exp_vec();
    logic        v;
    logic [31:0] i;
    logic [31:0] p;
    v = (q.size() != 0);
    i = v ? q[0].instr : 32'h0;
    p = v ? q[0].pc : last_pc;
    return {(q.size() != DEPTH), v, i, p, p + 32'd8, CW'(q.size())};
  endfunction

  // Drive one cycle of inputs, advance the model at the clock edge.
  task automatic cycle(input logic vf, input logic [31:0] i, input logic [31:0] p,
                       input logic rd, input logic fl);
    bit   pu;
    bit   po;
    ent_t e;
    @(negedge clk);
    valid_f = vf; instr_f = i; pc_f = p; ready_d = rd; flush = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      last_pc = RESET_PC;
    end else begin
      pu = vf && (q.size() != DEPTH);
      po = rd && (q.size() != 0);
      if (po) begin
        e = q.pop_front();
        last_pc = e.pc;
      end
      if (pu) q.push_back('{instr: i, pc: p});
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    last_pc = RESET_PC;
    #1;
    checks++; if (ready_f !== 1'b1) begin errors++; $display("FAIL reset_ready_f: got %b want 1", ready_f); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid_d: got %b want 0", valid_d); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL reset_instr_d: got %h want 0", instr_d); end
    checks++; if (pc_d !== 32'h3000) begin errors++; $display("FAIL reset_pc_d: got %h want 3000", pc_d); end
    checks++; if (pc8_d !== 32'h3008) begin errors++; $display("FAIL reset_pc8_d: got %h want 3008", pc8_d); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_stream();
    cycle(1'b1, 32'h2401_0001, 32'h3000, 1'b1, 1'b0);
    checks++; if (instr_d !== 32'h2401_0001) begin errors++; $display("FAIL stream_instr0: got %h want 24010001", instr_d); end
    checks++; if (pc_d !== 32'h3000) begin errors++; $display("FAIL stream_pc0: got %h want 3000", pc_d); end
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL stream_count0: got %0d want 1", count); end
    cycle(1'b1, 32'h2402_0002, 32'h3004, 1'b1, 1'b0);
    checks++; if (instr_d !== 32'h2402_0002) begin errors++; $display("FAIL stream_instr1: got %h want 24020002", instr_d); end
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL stream_count1: got %0d want 1", count); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b want 0", valid_d); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL stream_drain_instr: got %h want 0", instr_d); end
    checks++; if (pc_d !== 32'h3004) begin errors++; $display("FAIL stream_hold_pc: got %h want 3004", pc_d); end
    checks++; if (pc8_d !== 32'h300C) begin errors++; $display("FAIL stream_hold_pc8: got %h want 300c", pc8_d); end
    checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL stream_model: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_stall();
    cycle(1'b1, 32'h2401_0001, 32'h3000, 1'b0, 1'b0);
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL stall_count1: got %0d want 1", count); end
    cycle(1'b1, 32'h2402_0002, 32'h3004, 1'b0, 1'b0);
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL stall_count2: got %0d want 2", count); end
    checks++; if (ready_f !== 1'b0) begin errors++; $display("FAIL stall_ready_low: got %b want 0", ready_f); end
    cycle(1'b1, 32'h2403_0003, 32'h3008, 1'b0, 1'b0);
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL stall_no_overwrite: got %0d want 2", count); end
    checks++; if (instr_d !== 32'h2401_0001) begin errors++; $display("FAIL stall_head_hold: got %h want 24010001", instr_d); end
    checks++; if (pc_d !== 32'h3000) begin errors++; $display("FAIL stall_pc_hold: got %h want 3000", pc_d); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (instr_d !== 32'h2402_0002) begin errors++; $display("FAIL stall_pop1_instr: got %h want 24020002", instr_d); end
    checks++; if (pc_d !== 32'h3004) begin errors++; $display("FAIL stall_pop1_pc: got %h want 3004", pc_d); end
    checks++; if (ready_f !== 1'b1) begin errors++; $display("FAIL stall_ready_back: got %b want 1", ready_f); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (count !== '0) begin errors++; $display("FAIL stall_drained: got %0d want 0", count); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL stall_model: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    for (int k = 0; k < 3*DEPTH + 1; k++) begin
      cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0);
      checks++; if (count !== CW'(1)) begin errors++; $display("FAIL simul_count[%0d]: got %0d want 1", k, count); end
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL simul_head[%0d]: got %h want %h", k, obs, exp_vec()); end
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_pc_wrap();
    cycle(1'b1, 32'h1234_5678, 32'hFFFF_FFFC, 1'b0, 1'b0);
    checks++; if (pc8_d !== 32'h0000_0004) begin errors++; $display("FAIL pc8_wrap: got %h want 00000004", pc8_d); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h2401_0001, 32'h3100, 1'b0, 1'b0);
    cycle(1'b1, 32'h2402_0002, 32'h3104, 1'b0, 1'b0);
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL flush_pre_count: got %0d want 2", count); end
    cycle(1'b1, 32'hDEAD_BEEF, 32'h4000, 1'b1, 1'b1);
    checks++; if (count !== '0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", valid_d); end
    checks++; if (pc_d !== 32'h3000) begin errors++; $display("FAIL flush_pc: got %h want 3000", pc_d); end
    checks++; if (ready_f !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", ready_f); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (count !== '0) begin errors++; $display("FAIL flush_not_stored: got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 32'h2401_0001, 32'h3200, 1'b0, 1'b0);
    cycle(1'b1, 32'h2402_0002, 32'h3204, 1'b0, 1'b0);
    @(negedge clk);
    valid_f = 1'b0; ready_d = 1'b0;
    #2;
    reset = 1'b0;
    q.delete();
    last_pc = RESET_PC;
    #1;
    checks++; if (count !== '0) begin errors++; $display("FAIL async_count: got %0d want 0", count); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", valid_d); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL async_instr: got %h want 0", instr_d); end
    checks++; if (pc_d !== 32'h3000) begin errors++; $display("FAIL async_pc: got %h want 3000", pc_d); end
    checks++; if (pc8_d !== 32'h3008) begin errors++; $display("FAIL async_pc8: got %h want 3008", pc8_d); end
    checks++; if (ready_f !== 1'b1) begin errors++; $display("FAIL async_ready: got %b want 1", ready_f); end
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 32'h2405_0005, 32'h3010, 1'b0, 1'b0);
    checks++; if (instr_d !== 32'h2405_0005) begin errors++; $display("FAIL post_reset_instr: got %h want 24050005", instr_d); end
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL post_reset_count: got %0d want 1", count); end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL random[%0d]: got %h want %h", k, obs, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_simultaneous();
    test_pc_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the Fetch stage and the Decode stage of the 5-stage MIPS pipeline.
- Captures the fetched instruction and its PC from Fetch and presents them to Decode in order.
- Absorbs Decode stalls without losing fetched words.
- Drives the PC-enable back-pressure for Fetch and supports a one-cycle flush for pipeline redirects.

Parameters:
- DEPTH, 2: number of queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_3000: value driven on pc_d out of reset and while nothing has been popped.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr_f  input  32  instruction word from Fetch (InstrF).
- pc_f  input  32  PC of instr_f (PCF).
- valid_f  input  1  instr_f/pc_f hold a real fetched word this cycle.
- ready_f  output  1  queue can accept a word; drives Fetch's PC enable.
- instr_d  output  32  head instruction presented to Decode.
- pc_d  output  32  PC of head instruction.
- pc8_d  output  32  pc_d + 8, the link address for jal/jalr.
- valid_d  output  1  head entry is valid.
- ready_d  input  1  Decode accepts the head this cycle; low means stall.
- flush  input  1  discard all queued and incoming words.
- count  output  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Storage:
  - DEPTH-entry circular buffer of {instr, pc} with head and tail pointers of width $clog2(DEPTH).
  - Both pointers wrap modulo DEPTH.
- Push and pop conditions:
  - push = valid_f && ready_f && !flush.
  - pop = valid_d && ready_d && !flush.
  - On push: write {instr_f, pc_f} at tail; tail++.
  - On pop: head++.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
  - Neither: count unchanged.
- ready_f:
  - ready_f = (count != DEPTH), combinational from registered count only.
  - It does not depend on ready_d in the same cycle, so there is no combinational path from Decode to Fetch.
  - When full, Fetch holds its PC; a simultaneous pop frees space only from the next cycle.
- Head outputs:
  - valid_d = (count != 0).
  - instr_d = head entry instr when valid_d; 32'h0000_0000 (nop bubble) when empty.
  - pc_d = head entry pc when valid_d. When empty it holds the PC of the last popped entry, or RESET_PC if nothing has been popped since reset or the last flush.
  - pc8_d = pc_d + 8, 32-bit wrap-around, purely combinational.
- Latency: a word pushed at edge N is visible on instr_d/pc_d after edge N when the queue was empty (one-cycle IF->ID latency). Otherwise it is visible after all older entries have been popped.
- Ordering: strict FIFO. Branch delay slots are never dropped except by flush.
- Flush:
  - At the edge where flush=1: head=tail=0 and count=0.
  - pc_d reverts to RESET_PC.
  - Any push and pop in that cycle are ignored.
  - ready_f is 1 on the following cycle.
- Reset, while low at any time including mid-operation:
  - head=tail=count=0, valid_d=0, instr_d=0, pc_d=RESET_PC, pc8_d=RESET_PC+8, ready_f=1.
  - Storage contents are don't-care.
- Illegal case: valid_f while ready_f=0 is legal but ignored, with no overwrite; Fetch must re-present the word.
- Stall: when ready_d=0, all outputs hold steady while the queue fills to DEPTH, then ready_f drops.

Test Plan:
- Reset release with no input -> ready_f=1, valid_d=0, instr_d=0, pc_d=32'h3000, pc8_d=32'h3008, count=0.
- Stream: push 0x3000/0x24010001, 0x3004/0x24020002 with ready_d=1 every cycle -> each appears on instr_d one cycle after push; count toggles between 0 and 1; never exceeds 1.
- Stall: ready_d=0, push 3 words (0x3000, 0x3004, 0x3008) -> after 2 pushes count=2 and ready_f=0; the third word is not accepted; instr_d stays at the 0x3000 word. Raise ready_d -> pops in order 0x3000, 0x3004; ready_f=1 one cycle after the first pop.
- Simultaneous push/pop at count=1 -> count stays 1; head advances correctly; pointer wrap-around verified after more than DEPTH cycles.
- Flush with count=2 and valid_f=1 -> next cycle count=0, valid_d=0, pc_d=32'h3000, and the incoming word is not stored.
- Assert reset low mid-stream with count=2 -> outputs immediately at reset values without waiting for clk. After release, the first push reappears with one-cycle latency.
